// File: rtl/uart_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_core (with helper uart_core_fifo)
// Purpose  : full-duplex UART, runtime baud divisor, FWFT TX/RX FIFOs.
//            Parity state and checking are built when UART_PARITY_EN is defined.
// Revision : 1.0
// ============================================================================

module uart_core_fifo #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   count;

    assign full  = count[ADDR_BITS];
    assign empty = (count == '0);
    // Head reads as zero when empty so the port stays clean after reset.
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_core #(
    parameter int WORD_BITS      = 8,
    parameter int OVERSAMPLE     = 16,
    parameter int DIV_BITS       = 16,
    parameter int FIFO_ADDR_BITS = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [DIV_BITS-1:0]  baud_div_i,
    input  logic                 parity_odd_i,
    input  logic                 rx_i,
    output logic                 tx_o,
    input  logic [WORD_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic [WORD_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 tx_busy_o,
    output logic                 rx_frame_err_o,
    output logic                 rx_overrun_o,
    output logic                 rx_parity_err_o
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(WORD_BITS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    // ---------------- baud divider and input synchronizer ----------------
    logic [DIV_BITS-1:0] div_cnt;
    logic                tick;
    logic                rx_meta;
    logic                rx_sync;
    logic                out_of_reset;

    assign tick = (div_cnt >= baud_div_i);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            div_cnt      <= '0;
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            out_of_reset <= 1'b0;
        end else begin
            div_cnt      <= tick ? '0 : div_cnt + 1'b1;
            rx_meta      <= rx_i;
            rx_sync      <= rx_meta;
            out_of_reset <= 1'b1;
        end
    end

    // ---------------- FIFOs ----------------
    logic                 tx_push, tx_pop, tx_full, tx_empty;
    logic [WORD_BITS-1:0] tx_head;
    logic                 rx_push, rx_pop, rx_full, rx_empty;
    logic [WORD_BITS-1:0] rx_shift;

    assign tx_ready_o = out_of_reset && !tx_full;
    assign tx_push    = tx_valid_i && tx_ready_o;
    assign rx_valid_o = !rx_empty;
    assign rx_pop     = rx_ready_i && !rx_empty;

    uart_core_fifo #(.WIDTH(WORD_BITS), .ADDR_BITS(FIFO_ADDR_BITS)) u_tx_fifo (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .push(tx_push), .pop(tx_pop),
        .wdata(tx_data_i), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
    );

    uart_core_fifo #(.WIDTH(WORD_BITS), .ADDR_BITS(FIFO_ADDR_BITS)) u_rx_fifo (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .push(rx_push), .pop(rx_pop),
        .wdata(rx_shift), .rdata(rx_data_o), .full(rx_full), .empty(rx_empty)
    );

    // ---------------- transmitter ----------------
    state_t               tx_state, tx_state_n;
    logic [TW-1:0]        tx_tick, tx_tick_n;
    logic [BW-1:0]        tx_bit, tx_bit_n;
    logic [WORD_BITS-1:0] tx_shift, tx_shift_n;
    logic                 tx_line_n;
    logic                 tx_bit_end;
`ifdef UART_PARITY_EN
    logic                 tx_par, tx_par_n;
`endif

    assign tx_bit_end = tick && (tx_tick == TICK_LAST);
    assign tx_busy_o  = (tx_state != S_IDLE) || !tx_empty;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tx_state <= S_IDLE;
            tx_tick  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_o     <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_n;
            tx_tick  <= tx_tick_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_o     <= tx_line_n;
`ifdef UART_PARITY_EN
            tx_par   <= tx_par_n;
`endif
        end
    end

    // The line is registered from the current state, so the pin lags the FSM by one clock.
    always_comb begin
        tx_state_n = tx_state;
        tx_tick_n  = tx_tick;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        tx_line_n  = 1'b1;
`ifdef UART_PARITY_EN
        tx_par_n   = tx_par;
`endif
        if (tick) tx_tick_n = tx_bit_end ? '0 : tx_tick + 1'b1;
        case (tx_state)
            S_IDLE: begin
                tx_tick_n = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_n = S_START;
                end
            end
            S_START: begin
                tx_line_n = 1'b0;
                if (tx_bit_end) begin
                    tx_bit_n   = '0;
                    tx_state_n = S_DATA;
                end
            end
            S_DATA: begin
                tx_line_n = tx_shift[0];
                if (tx_bit_end) begin
                    tx_shift_n = tx_shift >> 1;
                    tx_bit_n   = tx_bit + 1'b1;
`ifdef UART_PARITY_EN
                    if (tx_bit == BIT_LAST) tx_state_n = S_PARITY;
`else
                    if (tx_bit == BIT_LAST) tx_state_n = S_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                tx_line_n = tx_par;
                if (tx_bit_end) tx_state_n = S_STOP;
            end
`endif
            S_STOP: begin
                tx_line_n = 1'b1;
                if (tx_bit_end) begin
                    // Chain straight into the next start bit to avoid an idle gap.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_state_n = S_START;
                    end else begin
                        tx_state_n = S_IDLE;
                    end
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
        if (tx_pop) begin
            tx_shift_n = tx_head;
`ifdef UART_PARITY_EN
            tx_par_n   = (^tx_head) ^ parity_odd_i;
`endif
        end
    end

    // ---------------- receiver ----------------
    state_t               rx_state, rx_state_n;
    logic [TW-1:0]        rx_tick, rx_tick_n;
    logic [BW-1:0]        rx_bit, rx_bit_n;
    logic [WORD_BITS-1:0] rx_shift_n;
    logic                 rx_done, frame_err_n, rx_sample;
`ifdef UART_PARITY_EN
    logic                 rx_par_bad, rx_par_bad_n, parity_err_n;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = parity_odd_i;
    assign rx_parity_err_o   = 1'b0;
`endif

    assign rx_sample = tick && (rx_tick == TICK_LAST);
    assign rx_push   = rx_done && (!rx_full || rx_pop);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_state        <= S_IDLE;
            rx_tick         <= '0;
            rx_bit          <= '0;
            rx_shift        <= '0;
            rx_frame_err_o  <= 1'b0;
            rx_overrun_o    <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad      <= 1'b0;
            rx_parity_err_o <= 1'b0;
`endif
        end else begin
            rx_state        <= rx_state_n;
            rx_tick         <= rx_tick_n;
            rx_bit          <= rx_bit_n;
            rx_shift        <= rx_shift_n;
            rx_frame_err_o  <= frame_err_n;
            rx_overrun_o    <= rx_done && rx_full && !rx_pop;
`ifdef UART_PARITY_EN
            rx_par_bad      <= rx_par_bad_n;
            rx_parity_err_o <= parity_err_n;
`endif
        end
    end

    always_comb begin
        rx_state_n   = rx_state;
        rx_tick_n    = rx_tick;
        rx_bit_n     = rx_bit;
        rx_shift_n   = rx_shift;
        rx_done      = 1'b0;
        frame_err_n  = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_bad_n = rx_par_bad;
        parity_err_n = 1'b0;
`endif
        if (tick) rx_tick_n = rx_sample ? '0 : rx_tick + 1'b1;
        case (rx_state)
            S_IDLE: begin
                rx_tick_n = '0;
                if (!rx_sync) rx_state_n = S_START;
            end
            S_START: begin
                // Mid start bit: a line already back high was a glitch.
                if (tick && (rx_tick == TICK_MID)) begin
                    rx_tick_n  = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_sample) begin
                    rx_shift_n = {rx_sync, rx_shift[WORD_BITS-1:1]};
                    rx_bit_n   = rx_bit + 1'b1;
`ifdef UART_PARITY_EN
                    if (rx_bit == BIT_LAST) rx_state_n = S_PARITY;
`else
                    if (rx_bit == BIT_LAST) rx_state_n = S_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (rx_sample) begin
                    rx_par_bad_n = rx_sync ^ (^rx_shift) ^ parity_odd_i;
                    rx_state_n   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (rx_sample) begin
                    if (!rx_sync) begin
                        frame_err_n = 1'b1;
                        rx_state_n  = S_BREAK;
                    end else begin
                        rx_state_n = S_IDLE;
`ifdef UART_PARITY_EN
                        if (rx_par_bad) parity_err_n = 1'b1;
                        else            rx_done      = 1'b1;
`else
                        rx_done = 1'b1;
`endif
                    end
                end
            end
            S_BREAK: begin
                if (rx_sync) rx_state_n = S_IDLE;
            end
            default: rx_state_n = S_IDLE;
        endcase
    end
endmodule

`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_core
// Purpose  : self-checking bench for uart_core: exact TX waveform, loopback,
//            overrun, frame error, glitch, optional parity and mid-frame reset.
// Revision : 1.0
// ============================================================================
module tb_uart_core;
    localparam int W  = 8;
    localparam int OS = 16;
    localparam int DB = 16;
    localparam int FA = 4;
    localparam int DEPTH = 1 << FA;
`ifdef UART_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME = W + PBITS + 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DB-1:0] baud_div = '0;
    logic          parity_odd = 1'b0;
    logic          loop = 1'b0;
    logic          rx_drv = 1'b1;
    logic          rx_line;
    logic          tx_line;
    logic [W-1:0]  tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [W-1:0]  rx_data;
    logic          rx_valid;
    logic          drain = 1'b0;
    logic          tx_busy;
    logic          frame_err, overrun, parity_err;

    assign rx_line = loop ? tx_line : rx_drv;

    uart_core #(.WORD_BITS(W), .OVERSAMPLE(OS), .DIV_BITS(DB), .FIFO_ADDR_BITS(FA)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .baud_div_i(baud_div), .parity_odd_i(parity_odd),
        .rx_i(rx_line), .tx_o(tx_line), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
        .rx_ready_i(drain), .tx_busy_o(tx_busy), .rx_frame_err_o(frame_err),
        .rx_overrun_o(overrun), .rx_parity_err_o(parity_err)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Passive observer: pulse counters and every word the consumer pops.
    int           frame_cnt = 0, overrun_cnt = 0, parity_cnt = 0, valid_cycles = 0;
    logic [W-1:0] rxq[$];
    always @(negedge clk) begin
        if (frame_err)  frame_cnt++;
        if (overrun)    overrun_cnt++;
        if (parity_err) parity_cnt++;
        if (rx_valid) begin
            valid_cycles++;
            if (drain) rxq.push_back(rx_data);
        end
    end

    int n_cmp = 0, n_bad = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Line level of bit k of a frame carrying d: start, LSB-first data, parity, stop.
    function automatic logic model_bit(input logic [W-1:0] d, input int k, input logic odd);
        int ones;
        if (k == 0) return 1'b0;
        if (k <= W) return d[k-1];
        if (PBITS == 1 && k == W + 1) begin
            ones = $countones(d) + (odd ? 1 : 0);
            return (ones % 2) == 1;
        end
        return 1'b1;
    endfunction

    task automatic set_drain(input logic v);
        @(posedge clk);
        #2 drain = v;
        @(negedge clk);
    endtask

    // Requires divisor 0 and an idle transmitter; checks every clock of n (1 or 2) frames.
    task automatic tx_check(input logic [W-1:0] w0, input logic [W-1:0] w1, input int n);
        check("tx_ready_before", tx_ready, 1);
        tx_data  = w0;
        tx_valid = 1'b1;
        @(negedge clk);
        check("tx_pre_start0", tx_line, 1);
        if (n == 2) tx_data = w1;
        else        tx_valid = 1'b0;
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_pre_start1", tx_line, 1);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < FRAME; k++)
                for (int s = 0; s < OS; s++) begin
                    @(negedge clk);
                    check("tx_bit", tx_line, model_bit((i == 0) ? w0 : w1, k, parity_odd));
                end
        check("tx_busy_end", tx_busy, 0);
    endtask

    task automatic send_word(input logic [W-1:0] d);
        int guard;
        guard    = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) check("send_timeout", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input int target, input int budget);
        int t;
        t = 0;
        while (rxq.size() < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("rx_count", rxq.size(), target);
    endtask

    task automatic wait_tx_idle(input int budget);
        int t;
        t = 0;
        while (tx_busy && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("tx_idle", tx_busy, 0);
    endtask

    task automatic drive_frame(input logic [W-1:0] d, input logic stop, input logic flip, input int div);
        int   bc;
        logic b;
        bc = OS * (div + 1);
        for (int k = 0; k < FRAME; k++) begin
            b = model_bit(d, k, parity_odd);
            if (PBITS == 1 && k == W + 1) b = b ^ flip;
            if (k == FRAME - 1) b = stop;
            rx_drv = b;
            repeat (bc) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        logic [W-1:0] w;
        logic [W-1:0] exp_q[$];
        int base, fc, oc, pc, vc, d, bc;

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        check("rst_tx_o", tx_line, 1);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_errs", {frame_err, overrun, parity_err}, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("ready_after_reset", tx_ready, 1);

        // Exact waveform: 0xA5 back-to-back with a random word, then a lone random word.
        baud_div = '0;
        w = W'($urandom);
        tx_check(8'hA5, w, 2);
        repeat (5) @(negedge clk);
        tx_check(W'($urandom), '0, 1);

        // Loopback with a random divisor: fixed corner words plus random words.
        loop = 1'b1;
        set_drain(1'b1);
        d = int'($urandom_range(0, 3));
        baud_div = DB'(d);
        repeat (40) @(negedge clk);
        base = rxq.size(); fc = frame_cnt; oc = overrun_cnt; pc = parity_cnt;
        exp_q.delete();
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h5A);
        for (int i = 0; i < 5; i++) exp_q.push_back(W'($urandom));
        foreach (exp_q[i]) send_word(exp_q[i]);
        wait_rx(base + exp_q.size(), exp_q.size() * FRAME * OS * (d + 1) + 400);
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < rxq.size()) check("loop_data", rxq[base + i], exp_q[i]);
        check("loop_no_errs", (frame_cnt - fc) + (overrun_cnt - oc) + (parity_cnt - pc), 0);

        // Overrun: 17 words with the consumer stalled; the 17th is dropped.
        set_drain(1'b0);
        d = int'($urandom_range(0, 1));
        baud_div = DB'(d);
        repeat (40) @(negedge clk);
        base = rxq.size(); oc = overrun_cnt;
        exp_q.delete();
        for (int i = 0; i < DEPTH + 1; i++) exp_q.push_back(W'($urandom));
        foreach (exp_q[i]) send_word(exp_q[i]);
        wait_tx_idle((DEPTH + 1) * FRAME * OS * (d + 1) + 400);
        repeat (OS * (d + 1)) @(negedge clk);
        check("ovr_pulses", overrun_cnt - oc, 1);
        check("ovr_valid", rx_valid, 1);
        set_drain(1'b1);
        wait_rx(base + DEPTH, 200);
        repeat (5) @(negedge clk);
        check("ovr_total", rxq.size(), base + DEPTH);
        for (int i = 0; i < DEPTH; i++)
            if (base + i < rxq.size()) check("ovr_data", rxq[base + i], exp_q[i]);
        check("ovr_drained", rx_valid, 0);

        // Directly driven RX: stop bit low, then a short glitch, then a good frame.
        loop = 1'b0;
        rx_drv = 1'b1;
        d = int'($urandom_range(0, 2));
        bc = OS * (d + 1);
        baud_div = DB'(d);
        repeat (40) @(negedge clk);
        fc = frame_cnt; vc = valid_cycles;
        drive_frame(W'($urandom), 1'b0, 1'b0, d);
        rx_drv = 1'b0;
        repeat (2 * bc) @(negedge clk);
        rx_drv = 1'b1;
        repeat (bc) @(negedge clk);
        check("ferr_pulse", frame_cnt - fc, 1);
        check("ferr_no_push", valid_cycles - vc, 0);
        fc = frame_cnt; vc = valid_cycles;
        rx_drv = 1'b0;
        repeat (4 * (d + 1)) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * bc) @(negedge clk);
        check("glitch_no_push", valid_cycles - vc, 0);
        check("glitch_no_err", frame_cnt - fc, 0);
        base = rxq.size();
        w = W'($urandom);
        drive_frame(w, 1'b1, 1'b0, d);
        wait_rx(base + 1, 3 * bc);
        if (base < rxq.size()) check("rx_after_break", rxq[base], w);

`ifdef UART_PARITY_EN
        // Odd parity: 0x01 carries parity 0; a flipped parity bit is rejected.
        baud_div = '0;
        parity_odd = 1'b1;
        repeat (5) @(negedge clk);
        tx_check(8'h01, '0, 1);
        pc = parity_cnt; vc = valid_cycles;
        drive_frame(W'($urandom), 1'b1, 1'b1, 0);
        repeat (2 * OS) @(negedge clk);
        check("par_pulse", parity_cnt - pc, 1);
        check("par_no_push", valid_cycles - vc, 0);
        base = rxq.size();
        w = W'($urandom);
        drive_frame(w, 1'b1, 1'b0, 0);
        wait_rx(base + 1, 3 * OS);
        if (base < rxq.size()) check("par_good_data", rxq[base], w);
        parity_odd = 1'b0;
`endif

        // Reset in the middle of a data bit with words still queued.
        baud_div = '0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) send_word(W'($urandom));
        repeat (40) @(negedge clk);
        check("pre_reset_busy", tx_busy, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_tx_o", tx_line, 1);
        check("mid_rst_busy", tx_busy, 0);
        check("mid_rst_ready", tx_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_empty", tx_busy, 0);
        check("post_rst_tx_o", tx_line, 1);
        tx_check(W'($urandom), '0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
